// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake game engine
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    CHECK,
    OVER
  } state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } coord_t;

  localparam logic [2:0] ADDR_DIR    = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_FOOD_X = 3'd2;
  localparam logic [2:0] ADDR_FOOD_Y = 3'd3;

  localparam logic [15:0] RESET_HEAD_X = 16'd50;
  localparam logic [15:0] RESET_HEAD_Y = 16'd40;
  localparam logic [15:0] RESET_TAIL_X = 16'd51;
  localparam logic [15:0] RESET_TAIL_Y = 16'd40;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'd2;
  endfunction

endpackage

// File: rtl/snake_tick.sv
// rtl/snake_tick.sv - game tick counter with enable and clear, one-cycle tick on wrap
module snake_tick #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = en && (count_q == LAST);
    count_d = count_q;
    if (clr || tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake game-logic FSM with register window, body store and collision checks
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W      = 53,
  parameter int GRID_H      = 80,
  parameter int MAX_LEN     = 6,
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] head_x,
  output logic [15:0] head_y,
  output logic [15:0] snake_length,
  output logic        step_pulse,
  output logic        game_over,
  output logic [15:0] score
);
  state_t      state_q, state_d;
  dir_t        cur_dir_q, cur_dir_d;
  dir_t        pending_dir_q, pending_dir_d;
  logic        pause_q, pause_d;
  logic [15:0] food_x_q, food_x_d;
  logic [15:0] food_y_q, food_y_d;
  coord_t      body_q [MAX_LEN];
  coord_t      body_d [MAX_LEN];
  logic [15:0] len_q, len_d;
  logic [15:0] score_q, score_d;
  logic        game_over_q, game_over_d;
  logic        step_pulse_q, step_pulse_d;
  coord_t      next_head_q, next_head_d;
  logic        wall_hit_q, wall_hit_d;

  logic   wr_en, start_req, reload, tick, self_hit, step_wall;
  coord_t step_head;
  dir_t   wr_dir, guard_dir;

  function automatic coord_t reset_cell(int i);
    coord_t c;
    c = '0;
    if (i == 0) c = '{x: RESET_HEAD_X, y: RESET_HEAD_Y};
    else if (i == 1) c = '{x: RESET_TAIL_X, y: RESET_TAIL_Y};
    return c;
  endfunction

  snake_tick #(.CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == RUN && !pause_q),
    .clr   (state_q != RUN),
    .tick  (tick)
  );

  assign wr_en     = chipselect && write;
  assign start_req = wr_en && (address == ADDR_CTRL) && writedata[0];
  assign wr_dir    = dir_t'(writedata[1:0]);
  // During STEP the pending direction is about to become current, so guard against its reverse.
  assign guard_dir = (state_q == STEP) ? pending_dir_q : cur_dir_q;

  // Wall test precedes the arithmetic so coordinates never wrap.
  always_comb begin
    step_head = body_q[0];
    step_wall = 1'b0;
    case (pending_dir_q)
      UP:      if (body_q[0].y == 16'd0) step_wall = 1'b1;
               else step_head.y = body_q[0].y - 16'd1;
      RIGHT:   if (body_q[0].x == 16'(GRID_W - 1)) step_wall = 1'b1;
               else step_head.x = body_q[0].x + 16'd1;
      DOWN:    if (body_q[0].y == 16'(GRID_H - 1)) step_wall = 1'b1;
               else step_head.y = body_q[0].y + 16'd1;
      default: if (body_q[0].x == 16'd0) step_wall = 1'b1;
               else step_head.x = body_q[0].x - 16'd1;
    endcase
  end

  // The tail segment leaves its cell on this step, so it cannot be hit.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN - 1; i++) begin
      if ((i + 1) < int'(len_q) && body_q[i] == next_head_q) self_hit = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_dir_d     = cur_dir_q;
    pending_dir_d = pending_dir_q;
    pause_d       = pause_q;
    food_x_d      = food_x_q;
    food_y_d      = food_y_q;
    body_d        = body_q;
    len_d         = len_q;
    score_d       = score_q;
    game_over_d   = game_over_q;
    step_pulse_d  = 1'b0;
    next_head_d   = next_head_q;
    wall_hit_d    = wall_hit_q;
    reload        = 1'b0;

    if (wr_en) begin
      case (address)
        ADDR_DIR:    if (!is_reverse(wr_dir, guard_dir)) pending_dir_d = wr_dir;
        ADDR_CTRL:   pause_d = writedata[1];
        ADDR_FOOD_X: food_x_d = writedata;
        ADDR_FOOD_Y: food_y_d = writedata;
        default:     ;
      endcase
    end

    case (state_q)
      IDLE, OVER: reload = start_req;
      RUN:        if (tick) state_d = STEP;
      STEP: begin
        cur_dir_d   = pending_dir_q;
        next_head_d = step_head;
        wall_hit_d  = step_wall;
        state_d     = CHECK;
      end
      CHECK: begin
        state_d = RUN;
        if (wall_hit_q || self_hit) begin
          state_d     = OVER;
          game_over_d = 1'b1;
        end else begin
          for (int i = MAX_LEN - 1; i > 0; i--) body_d[i] = body_q[i-1];
          body_d[0]    = next_head_q;
          step_pulse_d = 1'b1;
          if (next_head_q.x == food_x_q && next_head_q.y == food_y_q) begin
            score_d = score_q + 16'd1;
            if (len_q < 16'(MAX_LEN)) len_d = len_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      state_d       = RUN;
      cur_dir_d     = LEFT;
      pending_dir_d = LEFT;
      len_d         = 16'd2;
      score_d       = '0;
      game_over_d   = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) body_d[i] = reset_cell(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_dir_q     <= LEFT;
      pending_dir_q <= LEFT;
      pause_q       <= 1'b0;
      food_x_q      <= '0;
      food_y_q      <= '0;
      for (int i = 0; i < MAX_LEN; i++) body_q[i] <= reset_cell(i);
      len_q         <= 16'd2;
      score_q       <= '0;
      game_over_q   <= 1'b0;
      step_pulse_q  <= 1'b0;
      next_head_q   <= '0;
      wall_hit_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_dir_q     <= cur_dir_d;
      pending_dir_q <= pending_dir_d;
      pause_q       <= pause_d;
      food_x_q      <= food_x_d;
      food_y_q      <= food_y_d;
      body_q        <= body_d;
      len_q         <= len_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
      step_pulse_q  <= step_pulse_d;
      next_head_q   <= next_head_d;
      wall_hit_q    <= wall_hit_d;
    end
  end

  assign head_x       = body_q[0].x;
  assign head_y       = body_q[0].y;
  assign snake_length = len_q;
  assign step_pulse   = step_pulse_q;
  assign game_over    = game_over_q;
  assign score        = score_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - self-checking bench for snake_engine
module tb_snake_engine;
  localparam int TICK   = 4;
  localparam int PERIOD = TICK + 2;
  localparam int GW     = 53;
  localparam int GH     = 80;
  localparam int MAXL   = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] writedata = '0;
  logic [15:0] head_x, head_y, snake_length, score;
  logic        step_pulse, game_over;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;

  snake_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(MAXL), .TICK_CYCLES(TICK)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .head_x       (head_x),
    .head_y       (head_y),
    .snake_length (snake_length),
    .step_pulse   (step_pulse),
    .game_over    (game_over),
    .score        (score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          do_start;
    bit          set_dir;
    logic [1:0]  dir;
    bit          set_food;
    logic [15:0] fx;
    logic [15:0] fy;
    int          ex;
    int          ey;
    int          elen;
    int          esc;
    bit          eover;
  } row_t;

  row_t rows [17];

  // Reference model state
  int          mx[$];
  int          my[$];
  int          mdir, mpend, mscore;
  logic [15:0] mfx, mfy;
  bit          mover;
  int          rev [4] = '{2, 3, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic start_game();
    wr(3'd1, 16'd1);
    last_cyc = cyc;
  endtask

  task automatic wait_event(output bit pl, output bit ov, output logic [15:0] hx, output logic [15:0] hy,
                            output logic [15:0] ln, output logic [15:0] sc, output int dt);
    int n;
    n = 0;
    while (!(step_pulse || game_over) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(step_pulse || game_over)) begin
      tests++; fails++;
      $display("FAIL event_timeout: no step or game_over within %0d cycles", n);
    end
    pl = step_pulse; ov = game_over;
    hx = head_x; hy = head_y; ln = snake_length; sc = score;
    dt = cyc - last_cyc;
    last_cyc = cyc;
    if (pl) begin
      @(negedge clk);
      check("pulse_width", step_pulse, 0);
    end
  endtask

  task automatic step_check(input string tag, input int ex, input int ey, input int el, input int es,
                            input bit eo, input int edt);
    logic [15:0] hx, hy, ln, sc;
    bit pl, ov;
    int dt;
    wait_event(pl, ov, hx, hy, ln, sc, dt);
    check({tag, "_hx"}, hx, ex);
    check({tag, "_hy"}, hy, ey);
    check({tag, "_len"}, ln, el);
    check({tag, "_score"}, sc, es & 16'hFFFF);
    check({tag, "_over"}, ov, eo);
    check({tag, "_pulse"}, pl, !eo);
    check({tag, "_period"}, dt, edt);
  endtask

  task automatic model_reset();
    mx = '{50, 51}; my = '{40, 40};
    mdir = 3; mpend = 3; mscore = 0; mover = 0;
  endtask

  task automatic model_dir(input int d);
    if (d != rev[mdir]) mpend = d;
  endtask

  task automatic model_step();
    int nx, ny;
    bit hit;
    mdir = mpend;
    nx = mx[0]; ny = my[0];
    case (mdir)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    hit = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
    for (int i = 1; i < mx.size() - 1; i++)
      if (mx[i] == nx && my[i] == ny) hit = 1;
    if (hit) begin
      mover = 1;
    end else begin
      mx.push_front(nx); my.push_front(ny);
      if (nx == int'(mfx) && ny == int'(mfy)) begin
        mscore++;
        if (mx.size() > MAXL) begin void'(mx.pop_back()); void'(my.pop_back()); end
      end else begin
        void'(mx.pop_back()); void'(my.pop_back());
      end
    end
  endtask

  initial begin
    int np, d, k, fx, fy;
    rows[0]  = '{0, 0, 2'd0, 0, 16'd0,  16'd0,  49, 40, 2, 0, 0};
    rows[1]  = '{0, 1, 2'd1, 0, 16'd0,  16'd0,  48, 40, 2, 0, 0};
    rows[2]  = '{0, 1, 2'd0, 0, 16'd0,  16'd0,  48, 39, 2, 0, 0};
    rows[3]  = '{0, 1, 2'd3, 1, 16'd47, 16'd39, 47, 39, 3, 1, 0};
    rows[4]  = '{0, 0, 2'd0, 1, 16'd46, 16'd39, 46, 39, 4, 2, 0};
    rows[5]  = '{0, 0, 2'd0, 1, 16'd45, 16'd39, 45, 39, 5, 3, 0};
    rows[6]  = '{0, 0, 2'd0, 1, 16'd44, 16'd39, 44, 39, 6, 4, 0};
    rows[7]  = '{0, 0, 2'd0, 1, 16'd43, 16'd39, 43, 39, 6, 5, 0};
    rows[8]  = '{0, 0, 2'd0, 0, 16'd0,  16'd0,  42, 39, 6, 5, 0};
    rows[9]  = '{0, 1, 2'd0, 0, 16'd0,  16'd0,  42, 38, 6, 5, 0};
    rows[10] = '{0, 1, 2'd1, 0, 16'd0,  16'd0,  43, 38, 6, 5, 0};
    rows[11] = '{0, 1, 2'd2, 0, 16'd0,  16'd0,  43, 38, 6, 5, 1};
    rows[12] = '{1, 0, 2'd0, 1, 16'd49, 16'd40, 49, 40, 3, 1, 0};
    rows[13] = '{0, 0, 2'd0, 1, 16'd48, 16'd40, 48, 40, 4, 2, 0};
    rows[14] = '{0, 1, 2'd0, 0, 16'd0,  16'd0,  48, 39, 4, 2, 0};
    rows[15] = '{0, 1, 2'd1, 0, 16'd0,  16'd0,  49, 39, 4, 2, 0};
    rows[16] = '{0, 1, 2'd2, 0, 16'd0,  16'd0,  49, 40, 4, 2, 0};

    repeat (3) @(negedge clk);
    check("rst_hx", head_x, 50);
    check("rst_hy", head_y, 40);
    check("rst_len", snake_length, 2);
    check("rst_pulse", step_pulse, 0);
    check("rst_over", game_over, 0);
    check("rst_score", score, 0);
    reset = 1'b0;

    np = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_pulse) np++;
    end
    check("idle_no_step", np, 0);
    check("idle_hx", head_x, 50);

    start_game();
    for (int r = 0; r < 17; r++) begin
      if (rows[r].do_start) begin
        start_game();
        check($sformatf("row%0d_start_hx", r), head_x, 50);
        check($sformatf("row%0d_start_score", r), score, 0);
        check($sformatf("row%0d_start_over", r), game_over, 0);
      end
      if (rows[r].set_dir) wr(3'd0, {14'd0, rows[r].dir});
      if (rows[r].set_food) begin
        wr(3'd2, rows[r].fx);
        wr(3'd3, rows[r].fy);
      end
      step_check($sformatf("row%0d", r), rows[r].ex, rows[r].ey, rows[r].elen, rows[r].esc,
                 rows[r].eover, PERIOD);
    end

    // Pause for 10 counting cycles mid-count
    wr(3'd1, 16'd2);
    repeat (9) @(negedge clk);
    wr(3'd1, 16'd0);
    step_check("pause", 49, 41, 4, 2, 0, PERIOD + 10);

    // Reset asserted while the engine sits in CHECK
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstchk_hx", head_x, 50);
    check("rstchk_hy", head_y, 40);
    check("rstchk_len", snake_length, 2);
    check("rstchk_score", score, 0);
    check("rstchk_pulse", step_pulse, 0);
    check("rstchk_over", game_over, 0);
    reset = 1'b0;
    @(negedge clk);

    // Walk into the left wall
    start_game();
    wr(3'd2, 16'd52);
    wr(3'd3, 16'd79);
    for (int x = 49; x >= 0; x--) step_check($sformatf("wall_x%0d", x), x, 40, 2, 0, 0, PERIOD);
    step_check("wall_hit", 0, 40, 2, 0, 1, PERIOD);
    repeat (12) @(negedge clk);
    check("over_frozen_hx", head_x, 0);
    check("over_frozen_go", game_over, 1);
    start_game();
    check("restart_hx", head_x, 50);
    check("restart_hy", head_y, 40);
    check("restart_score", score, 0);
    check("restart_over", game_over, 0);

    // Randomized play against the reference model
    model_reset();
    mfx = 16'd52; mfy = 16'd79;
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(1, 0) == 1) begin
        d = $urandom_range(3, 0);
        wr(3'd0, 16'(d));
        model_dir(d);
      end
      if ($urandom_range(2, 0) == 0) begin
        k = $urandom_range(3, 0);
        fx = mx[0] + ((k == 1) ? 1 : 0) - ((k == 3) ? 1 : 0);
        fy = my[0] + ((k == 2) ? 1 : 0) - ((k == 0) ? 1 : 0);
        mfx = 16'(fx); mfy = 16'(fy);
        wr(3'd2, mfx);
        wr(3'd3, mfy);
      end
      model_step();
      step_check($sformatf("rnd%0d", s), mx[0], my[0], mx.size(), mscore, mover, PERIOD);
      if (mover) begin
        start_game();
        model_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
